fir_mult_sequencer: RTL and testbench

//   Initiator side of the 10-bit float multiplier handshake (en / out_avl).

---
 rtl/flpt10_pkg.sv | 27 ++
 rtl/fir_delay_line.sv | 34 +++
 rtl/fir_mult_sequencer.sv | 165 ++++++++++++++++
 tb/tb_fir_mult_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/flpt10_pkg.sv
// Shared definitions for the 10-bit float datapath (1 sign, 5 exp, 4 mantissa, bias 15)
// and the multiplier sequencer state encodings.
package flpt10_pkg;
  localparam int FLT_W    = 10;
  localparam int EXP_W    = 5;
  localparam int MAN_W    = 4;
  localparam int EXP_BIAS = 15;

  localparam logic [FLT_W-1:0] FLT_ZERO = 10'h000;
  localparam logic [FLT_W-1:0] FLT_QNAN = 10'h3F8;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_SHIFT = 4'd1;
  localparam logic [3:0] ST_ISSUE = 4'd2;
  localparam logic [3:0] ST_WAIT  = 4'd3;
  localparam logic [3:0] ST_EMIT  = 4'd4;
  localparam logic [3:0] ST_DONE  = 4'd5;

  typedef enum logic [3:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_ISSUE = ST_ISSUE,
    S_WAIT  = ST_WAIT,
    S_EMIT  = ST_EMIT,
    S_DONE  = ST_DONE
  } seq_state_e;
endpackage

// File: rtl/fir_delay_line.sv
// NTAPS-deep sample delay line: one shift per enable, newest at index 0, indexed read.
module fir_delay_line
  import flpt10_pkg::*;
#(
  parameter int NTAPS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     shift_en,
  input  logic [FLT_W-1:0]         din,
  input  logic [$clog2(NTAPS)-1:0] rd_idx,
  output logic [FLT_W-1:0]         rd_data
);
  logic [FLT_W-1:0] dl_q [NTAPS];
  logic [FLT_W-1:0] dl_d [NTAPS];

  always_comb begin
    dl_d = dl_q;
    if (shift_en) begin
      dl_d[0] = din;
      for (int k = 1; k < NTAPS; k++) dl_d[k] = dl_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NTAPS; k++) dl_q[k] <= FLT_ZERO;
    end else begin
      dl_q <= dl_d;
    end
  end

  assign rd_data = dl_q[rd_idx];
endmodule

// File: rtl/fir_mult_sequencer.sv
// Shifts in one sample per start, then walks all taps through the external float
// multiplier one request at a time, streaming each product with its tap index.
module fir_mult_sequencer
  import flpt10_pkg::*;
#(
  parameter int NTAPS   = 8,
  parameter int TIMEOUT = 63
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [FLT_W-1:0]         sample_in,
  input  logic                     coef_we,
  input  logic [$clog2(NTAPS)-1:0] coef_addr,
  input  logic [FLT_W-1:0]         coef_data,
  output logic                     mult_en,
  output logic [FLT_W-1:0]         mult_a,
  output logic [FLT_W-1:0]         mult_b,
  input  logic [FLT_W-1:0]         mult_z,
  input  logic                     mult_avl,
  output logic                     prod_valid,
  output logic [FLT_W-1:0]         prod_data,
  output logic [$clog2(NTAPS)-1:0] prod_idx,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout_err
);
  localparam int IW = $clog2(NTAPS);

  seq_state_e       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             avl_q;
  logic [FLT_W-1:0] sample_q, sample_d;
  logic [FLT_W-1:0] coef_q [NTAPS];
  logic [FLT_W-1:0] coef_d [NTAPS];
  logic             mult_en_q, mult_en_d;
  logic [FLT_W-1:0] mult_a_q, mult_a_d, mult_b_q, mult_b_d;
  logic             prod_valid_q, prod_valid_d;
  logic [FLT_W-1:0] prod_data_q, prod_data_d;
  logic [IW-1:0]    prod_idx_q, prod_idx_d;
  logic             busy_q, busy_d, done_q, done_d, terr_q, terr_d;
  logic             shift_en, avl_rise;
  logic [FLT_W-1:0] dl_rd;

  fir_delay_line #(.NTAPS(NTAPS)) u_dl (
    .clk     (clk),
    .rst     (rst),
    .shift_en(shift_en),
    .din     (sample_q),
    .rd_idx  (idx_q),
    .rd_data (dl_rd)
  );

  // The avl level may linger from a previous product; only a fresh rising edge is a result.
  assign avl_rise = mult_avl & ~avl_q;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    sample_d     = sample_q;
    coef_d       = coef_q;
    mult_a_d     = mult_a_q;
    mult_b_d     = mult_b_q;
    prod_data_d  = prod_data_q;
    prod_idx_d   = prod_idx_q;
    prod_valid_d = 1'b0;
    terr_d       = terr_q;
    shift_en     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (coef_we) coef_d[coef_addr] = coef_data;
        if (start) begin
          sample_d = sample_in;
          terr_d   = 1'b0;
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shift_en = 1'b1;
        idx_d    = '0;
        state_d  = S_ISSUE;
      end
      S_ISSUE: begin
        mult_a_d = dl_rd;
        mult_b_d = coef_q[idx_q];
        cnt_d    = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (avl_rise) begin
          prod_data_d  = mult_z;
          prod_idx_d   = idx_q;
          prod_valid_d = 1'b1;
          state_d      = S_EMIT;
        end else if (cnt_q == 8'(TIMEOUT)) begin
          terr_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_EMIT: begin
        if (idx_q == IW'(NTAPS - 1)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = S_ISSUE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    mult_en_d = (state_d == S_WAIT);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      avl_q        <= 1'b0;
      sample_q     <= FLT_ZERO;
      for (int k = 0; k < NTAPS; k++) coef_q[k] <= FLT_ZERO;
      mult_en_q    <= 1'b0;
      mult_a_q     <= FLT_ZERO;
      mult_b_q     <= FLT_ZERO;
      prod_valid_q <= 1'b0;
      prod_data_q  <= FLT_ZERO;
      prod_idx_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      terr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      avl_q        <= mult_avl;
      sample_q     <= sample_d;
      coef_q       <= coef_d;
      mult_en_q    <= mult_en_d;
      mult_a_q     <= mult_a_d;
      mult_b_q     <= mult_b_d;
      prod_valid_q <= prod_valid_d;
      prod_data_q  <= prod_data_d;
      prod_idx_q   <= prod_idx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      terr_q       <= terr_d;
    end
  end

  assign mult_en     = mult_en_q;
  assign mult_a      = mult_a_q;
  assign mult_b      = mult_b_q;
  assign prod_valid  = prod_valid_q;
  assign prod_data   = prod_data_q;
  assign prod_idx    = prod_idx_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = terr_q;
endmodule

// File: tb/tb_fir_mult_sequencer.sv
// Bench for fir_mult_sequencer: behavioural float multiplier plus a product scoreboard.
module tb_fir_mult_sequencer;
  localparam int NTAPS   = 8;
  localparam int TIMEOUT = 63;
  localparam int LAT     = 3;

  typedef struct {
    logic [2:0] idx;
    logic [9:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, start, coef_we;
  logic [9:0] sample_in, coef_data;
  logic [2:0] coef_addr;
  logic       mult_en, prod_valid, busy, done, timeout_err;
  logic [9:0] mult_a, mult_b, prod_data;
  logic [9:0] mult_z = 10'h000;
  logic       mult_avl = 1'b0;
  logic [2:0] prod_idx;

  int total = 0, bad = 0, pv_cnt = 0, mmode = 0;
  exp_t sb[$];
  logic [9:0] m_dl [NTAPS];
  logic [9:0] m_coef [NTAPS];

  fir_mult_sequencer #(.NTAPS(NTAPS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .sample_in(sample_in),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .mult_en(mult_en), .mult_a(mult_a), .mult_b(mult_b),
    .mult_z(mult_z), .mult_avl(mult_avl),
    .prod_valid(prod_valid), .prod_data(prod_data), .prod_idx(prod_idx),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Truncating normal-only multiply; zero exponent treated as zero.
  function automatic logic [9:0] fmul(input logic [9:0] a, input logic [9:0] b);
    logic [9:0] p;
    int e;
    if (a[8:4] == 5'd0 || b[8:4] == 5'd0) return 10'h000;
    p = {5'd0, 1'b1, a[3:0]} * {5'd0, 1'b1, b[3:0]};
    e = int'(a[8:4]) + int'(b[8:4]) - 15;
    if (p[9]) return {a[9] ^ b[9], 5'(e + 1), p[8:5]};
    return {a[9] ^ b[9], 5'(e), p[7:4]};
  endfunction

  // Multiplier model. mode 0: normal, 1: qNaN result with avl left high, 2: never answers.
  logic en_prev = 1'b0;
  int   mcnt = 0;
  always @(posedge clk) begin
    en_prev <= mult_en;
    if (mult_en && !en_prev) begin
      mult_avl <= 1'b0;
      mcnt     <= LAT;
    end else if (mcnt > 1) begin
      mcnt <= mcnt - 1;
    end else if (mcnt == 1) begin
      mcnt <= 0;
      if (mmode != 2) begin
        mult_avl <= 1'b1;
        mult_z   <= (mmode == 1) ? 10'h3F8 : fmul(mult_a, mult_b);
      end
    end
  end

  always @(negedge clk) begin
    if (prod_valid) begin
      pv_cnt++;
      if (sb.size() == 0) begin
        chk("pv_unexpected", 32'(sb.size()), 1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pv_data", 32'(prod_data), 32'(e.data));
        chk("pv_idx", 32'(prod_idx), 32'(e.idx));
        chk("pv_en_low", 32'(mult_en), 0);
      end
    end
  end

  task automatic write_coef(input logic [2:0] a, input logic [9:0] d);
    @(posedge clk); #1;
    coef_we = 1'b1; coef_addr = a; coef_data = d;
    @(posedge clk); #1;
    coef_we = 1'b0;
    m_coef[a] = d;
  endtask

  task automatic launch(input logic [9:0] s);
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1; sample_in = s;
    for (int k = NTAPS - 1; k > 0; k--) m_dl[k] = m_dl[k-1];
    m_dl[0] = s;
    if (mmode != 2) begin
      for (int k = 0; k < NTAPS; k++) begin
        e.idx  = 3'(k);
        e.data = (mmode == 1) ? 10'h3F8 : fmul(m_dl[k], m_coef[k]);
        sb.push_back(e);
      end
    end
    @(posedge clk); #1;
    start = 1'b0; sample_in = 10'h2AA;
  endtask

  task automatic wait_done(input string tag, input int budget, output int n);
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(done), 1);
  endtask

  initial begin
    int n, pv0;
    logic [9:0] smp [4];
    smp[0] = 10'h0F0; smp[1] = 10'h100; smp[2] = 10'h108; smp[3] = 10'h110;
    for (int k = 0; k < NTAPS; k++) begin m_dl[k] = 10'h000; m_coef[k] = 10'h000; end
    rst = 1'b1; start = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_data = '0; sample_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_en", 32'(mult_en), 0);
    chk("rst_pv", 32'(prod_valid), 0);
    chk("rst_terr", 32'(timeout_err), 0);
    chk("rst_ab", 32'({mult_a, mult_b}), 0);
    @(posedge clk); #1 rst = 1'b0;

    // unit coefficients, single sample 2.0
    for (int k = 0; k < NTAPS; k++) write_coef(3'(k), 10'h0F0);
    pv0 = pv_cnt;
    launch(10'h100);
    @(negedge clk);
    chk("seq_busy", 32'(busy), 1);
    wait_done("t1_done", 200, n);
    chk("t1_busy_in_done", 32'(busy), 1);
    chk("t1_pv_count", 32'(pv_cnt - pv0), NTAPS);
    chk("t1_sb_empty", 32'(sb.size()), 0);
    @(negedge clk);
    chk("t1_done_pulse", 32'(done), 0);
    chk("t1_idle", 32'(busy), 0);

    // distinct coefficients, four consecutive samples
    write_coef(3'd0, 10'h0F0); write_coef(3'd1, 10'h100);
    write_coef(3'd2, 10'h0F8); write_coef(3'd3, 10'h108);
    for (int i = 0; i < 4; i++) begin
      launch(smp[i]);
      wait_done("t2_done", 200, n);
    end
    chk("t2_sb_empty", 32'(sb.size()), 0);

    // qNaN with avl left high: one capture per tap
    mmode = 1; pv0 = pv_cnt;
    launch(10'h108);
    wait_done("t3_done", 200, n);
    chk("t3_pv_count", 32'(pv_cnt - pv0), NTAPS);
    repeat (5) @(negedge clk);
    chk("t3_no_extra", 32'(pv_cnt - pv0), NTAPS);

    // multiplier never answers
    mmode = 2; pv0 = pv_cnt;
    launch(10'h0F0);
    wait_done("t4_done", 300, n);
    chk("t4_terr", 32'(timeout_err), 1);
    chk("t4_en", 32'(mult_en), 0);
    chk("t4_len", 32'(n >= TIMEOUT), 1);
    chk("t4_no_pv", 32'(pv_cnt - pv0), 0);
    @(negedge clk);
    chk("t4_terr_sticky", 32'(timeout_err), 1);
    mmode = 0;
    launch(10'h100);
    @(negedge clk);
    chk("t4_terr_clr", 32'(timeout_err), 0);
    wait_done("t4b_done", 200, n);

    // start / coef_we while busy are ignored
    launch(10'h110);
    repeat (4) @(posedge clk);
    #1 start = 1'b1; sample_in = 10'h3FF; coef_we = 1'b1; coef_addr = 3'd0; coef_data = 10'h000;
    repeat (3) @(posedge clk);
    #1 start = 1'b0; coef_we = 1'b0;
    wait_done("t5_done", 200, n);
    launch(10'h0F0);
    wait_done("t5b_done", 200, n);
    chk("t5_sb_empty", 32'(sb.size()), 0);

    // reset in WAIT of tap 3, late avl edge must not produce a product
    launch(10'h100);
    n = 0;
    while (!(prod_valid && prod_idx == 3'd2) && n < 200) begin @(negedge clk); n++; end
    chk("t6_reach_tap2", 32'(prod_valid && prod_idx == 3'd2), 1);
    n = 0;
    while (!mult_en && n < 20) begin @(negedge clk); n++; end
    chk("t6_wait_tap3", 32'(mult_en), 1);
    @(posedge clk); #1 rst = 1'b1;
    sb.delete();
    for (int k = 0; k < NTAPS; k++) begin m_dl[k] = 10'h000; m_coef[k] = 10'h000; end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    pv0 = pv_cnt;
    chk("t6_busy", 32'(busy), 0);
    chk("t6_en", 32'(mult_en), 0);
    chk("t6_outs", 32'({prod_valid, done, timeout_err, prod_idx, prod_data}), 0);
    chk("t6_ab", 32'({mult_a, mult_b}), 0);
    repeat (10) @(negedge clk);
    chk("t6_late_avl", 32'(pv_cnt - pv0), 0);
    launch(10'h100);
    wait_done("t6b_done", 200, n);
    chk("t6_sb_empty", 32'(sb.size()), 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
